// File: rtl/static_pkg.sv
// Shared constants and FSM encoding for the static-segment access block.
package static_pkg;

    localparam int AW_DEF = 20;
    localparam int DW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

endpackage

// File: rtl/static_access.sv
// Single-word load/store into a static segment at seg_base + static pointer.
// Define STATIC_BOUNDS_CHECK_EN to compile in the offset >= seg_limit fault path.
module static_access
    import static_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          we,
    input  logic [AW-1:0] seg_base,
    input  logic [AW-1:0] offset,
    input  logic [AW-1:0] seg_limit,
    input  logic [DW-1:0] wdata,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          fault,
    output logic          ptr_inc,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    state_t state, state_n;
    logic   capture;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        capture = 1'b0;
        unique case (state)
            IDLE: if (start) begin
`ifdef STATIC_BOUNDS_CHECK_EN
                if (offset >= seg_limit) begin
                    state_n = FAULT;
                end else begin
                    state_n = REQ;
                    capture = 1'b1;
                end
`else
                state_n = REQ;
                capture = 1'b1;
`endif
            end
            REQ:   if (mem_ack) state_n = DONE;
            DONE:  state_n = IDLE;
            FAULT: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Request fields stay frozen from capture until the next accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (capture) begin
            mem_addr  <= seg_base + offset;
            mem_we    <= we;
            mem_wdata <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             rdata <= '0;
        else if (state == REQ && mem_ack && !mem_we) rdata <= mem_rdata;
    end

    assign busy    = (state != IDLE);
    assign mem_req = (state == REQ);
    assign ptr_inc = (state == DONE);

`ifdef STATIC_BOUNDS_CHECK_EN
    assign fault = (state == FAULT);
    assign done  = (state == DONE) || (state == FAULT);
`else
    logic unused_seg_limit;
    assign unused_seg_limit = ^seg_limit;
    assign fault = 1'b0;
    assign done  = (state == DONE);
`endif

endmodule
